// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, FSM states
// and the datapath mux-select constants.
package mc_pkg;

    // Opcode encodings (BNE is only decoded when the controller enables it)
    localparam logic [5:0] OP_RT   = 6'd0;
    localparam logic [5:0] OP_ADDI = 6'd1;
    localparam logic [5:0] OP_SLTI = 6'd2;
    localparam logic [5:0] OP_LW   = 6'd3;
    localparam logic [5:0] OP_SW   = 6'd4;
    localparam logic [5:0] OP_BEQ  = 6'd5;
    localparam logic [5:0] OP_J    = 6'd6;
    localparam logic [5:0] OP_JR   = 6'd7;
    localparam logic [5:0] OP_JAL  = 6'd8;
    localparam logic [5:0] OP_BNE  = 6'd9;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_ALU_WB   = 4'd4,
        ST_MEM_ADDR = 4'd5,
        ST_MEM_RD   = 4'd6,
        ST_MEM_WB   = 4'd7,
        ST_MEM_WR   = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_JREG     = 4'd11,
        ST_JLINK    = 4'd12
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_SLT   = 2'd2;
    localparam logic [1:0] ALUOP_FUNCT = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_REGA   = 2'd3;

    localparam logic [1:0] SRCB_REG     = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    localparam logic [1:0] DW_ALU  = 2'd0;
    localparam logic [1:0] DW_LINK = 2'd1;
    localparam logic [1:0] DW_SLT  = 2'd2;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> instruction register / datapath bundle. The controller
// owns the master side; the datapath (or a bench) owns the slave side.
interface multicycle_controller_if #(
    parameter int unsigned OPC_W = 6,
    parameter int unsigned CNT_W = 16
);
    logic [OPC_W-1:0] opcode;
    logic             ALUZeroFlag;
    logic             mem_ready;

    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             IRWrite;
    logic             MemRead;
    logic             MemWrite;
    logic             MemtoReg;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       RegDst;
    logic [1:0]       DataWrite;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [1:0]       PCSource;
    logic             PCWriteEn;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, ALUZeroFlag, mem_ready,
        output PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite,
               MemtoReg, RegWrite, ALUSrcA, RegDst, DataWrite, ALUSrcB,
               ALUOp, PCSource, PCWriteEn, illegal, instr_count
    );

    modport slave (
        output opcode, ALUZeroFlag, mem_ready,
        input  PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite,
               MemtoReg, RegWrite, ALUSrcA, RegDst, DataWrite, ALUSrcB,
               ALUOp, PCSource, PCWriteEn, illegal, instr_count
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multi-cycle MIPS datapath. Strobes decode from
// the current state and latched opcode; memory stalls are handled by holding
// in FETCH / MEM_RD / MEM_WR until mem_ready. Also counts retired
// instructions and pulses illegal on an undecodable opcode.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int unsigned OPC_W  = 6,
    parameter int unsigned CNT_W  = 16,
    parameter bit          BNE_EN = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    multicycle_controller_if.master bus
);

    state_t           r_state;
    state_t           w_next;
    logic [OPC_W-1:0] r_opcode;
    logic [OPC_W-1:0] w_op;
    logic [CNT_W-1:0] r_count;

    logic w_is_rt, w_is_addi, w_is_slti, w_is_lw, w_is_sw;
    logic w_is_beq, w_is_bne, w_is_j, w_is_jr, w_is_jal;
    logic w_retire;

    logic       w_pcwrite, w_pcwrite_cond, w_iord, w_irwrite, w_memread;
    logic       w_memwrite, w_memtoreg, w_regwrite, w_alusrca, w_illegal;
    logic [1:0] w_regdst, w_datawrite, w_alusrcb, w_aluop, w_pcsource;

    // IR is only guaranteed valid from DECODE; later states use the copy taken there
    assign w_op = (r_state == ST_DECODE) ? bus.opcode : r_opcode;

    assign w_is_rt   = (w_op == OPC_W'(OP_RT));
    assign w_is_addi = (w_op == OPC_W'(OP_ADDI));
    assign w_is_slti = (w_op == OPC_W'(OP_SLTI));
    assign w_is_lw   = (w_op == OPC_W'(OP_LW));
    assign w_is_sw   = (w_op == OPC_W'(OP_SW));
    assign w_is_beq  = (w_op == OPC_W'(OP_BEQ));
    assign w_is_bne  = BNE_EN && (w_op == OPC_W'(OP_BNE));
    assign w_is_j    = (w_op == OPC_W'(OP_J));
    assign w_is_jr   = (w_op == OPC_W'(OP_JR));
    assign w_is_jal  = (w_op == OPC_W'(OP_JAL));

    // State register and opcode latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_FETCH;
            r_opcode <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) begin
                r_opcode <= bus.opcode;
            end
        end
    end

    // Next-state and per-state strobe decode
    always_comb begin
        w_next         = r_state;
        w_pcwrite      = 1'b0;
        w_pcwrite_cond = 1'b0;
        w_iord         = 1'b0;
        w_irwrite      = 1'b0;
        w_memread      = 1'b0;
        w_memwrite     = 1'b0;
        w_memtoreg     = 1'b0;
        w_regwrite     = 1'b0;
        w_alusrca      = 1'b0;
        w_illegal      = 1'b0;
        w_regdst       = REGDST_RT;
        w_datawrite    = DW_ALU;
        w_alusrcb      = SRCB_REG;
        w_aluop        = ALUOP_ADD;
        w_pcsource     = PCSRC_ALU;
        case (r_state)
            ST_FETCH: begin
                w_memread = 1'b1;
                w_alusrcb = SRCB_FOUR;
                if (bus.mem_ready) begin
                    w_irwrite = 1'b1;
                    w_pcwrite = 1'b1;
                    w_next    = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Speculatively form the branch target into ALUOut
                w_alusrcb = SRCB_IMM_SH2;
                if (w_is_rt)                   w_next = ST_EXEC_R;
                else if (w_is_addi || w_is_slti) w_next = ST_EXEC_I;
                else if (w_is_lw || w_is_sw)   w_next = ST_MEM_ADDR;
                else if (w_is_beq || w_is_bne) w_next = ST_BRANCH;
                else if (w_is_j)               w_next = ST_JUMP;
                else if (w_is_jr)              w_next = ST_JREG;
                else if (w_is_jal)             w_next = ST_JLINK;
                else begin
                    w_illegal = 1'b1;
                    w_next    = ST_FETCH;
                end
            end
            ST_EXEC_R: begin
                w_alusrca = 1'b1;
                w_aluop   = ALUOP_FUNCT;
                w_next    = ST_ALU_WB;
            end
            ST_EXEC_I: begin
                w_alusrca = 1'b1;
                w_alusrcb = SRCB_IMM;
                w_aluop   = w_is_slti ? ALUOP_SLT : ALUOP_ADD;
                w_next    = ST_ALU_WB;
            end
            ST_ALU_WB: begin
                w_regwrite = 1'b1;
                if (w_is_rt)   w_regdst    = REGDST_RD;
                if (w_is_slti) w_datawrite = DW_SLT;
                w_next = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                w_alusrca = 1'b1;
                w_alusrcb = SRCB_IMM;
                w_next    = w_is_lw ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                w_memread = 1'b1;
                w_iord    = 1'b1;
                if (bus.mem_ready) w_next = ST_MEM_WB;
            end
            ST_MEM_WB: begin
                w_regwrite = 1'b1;
                w_memtoreg = 1'b1;
                w_next     = ST_FETCH;
            end
            ST_MEM_WR: begin
                w_memwrite = 1'b1;
                w_iord     = 1'b1;
                if (bus.mem_ready) w_next = ST_FETCH;
            end
            ST_BRANCH: begin
                w_alusrca      = 1'b1;
                w_aluop        = ALUOP_SUB;
                w_pcwrite_cond = 1'b1;
                w_pcsource     = PCSRC_ALUOUT;
                w_next         = ST_FETCH;
            end
            ST_JUMP: begin
                w_pcwrite  = 1'b1;
                w_pcsource = PCSRC_JUMP;
                w_next     = ST_FETCH;
            end
            ST_JREG: begin
                w_pcwrite  = 1'b1;
                w_pcsource = PCSRC_REGA;
                w_next     = ST_FETCH;
            end
            ST_JLINK: begin
                w_pcwrite   = 1'b1;
                w_pcsource  = PCSRC_JUMP;
                w_regwrite  = 1'b1;
                w_regdst    = REGDST_RA;
                w_datawrite = DW_LINK;
                w_next      = ST_FETCH;
            end
            default: w_next = ST_FETCH;
        endcase
    end

    // An instruction retires only when a terminal state hands back to FETCH
    assign w_retire = (w_next == ST_FETCH) &&
                      (r_state inside {ST_ALU_WB, ST_MEM_WB, ST_MEM_WR, ST_BRANCH,
                                       ST_JUMP, ST_JREG, ST_JLINK});

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (w_retire) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // PC and IR writes are suppressed while reset is held
    assign bus.PCWrite     = w_pcwrite & rst;
    assign bus.IRWrite     = w_irwrite & rst;
    assign bus.PCWriteEn   = (w_pcwrite | (w_pcwrite_cond & (bus.ALUZeroFlag ^ w_is_bne))) & rst;
    assign bus.PCWriteCond = w_pcwrite_cond;
    assign bus.IorD        = w_iord;
    assign bus.MemRead     = w_memread;
    assign bus.MemWrite    = w_memwrite;
    assign bus.MemtoReg    = w_memtoreg;
    assign bus.RegWrite    = w_regwrite;
    assign bus.ALUSrcA     = w_alusrca;
    assign bus.RegDst      = w_regdst;
    assign bus.DataWrite   = w_datawrite;
    assign bus.ALUSrcB     = w_alusrcb;
    assign bus.ALUOp       = w_aluop;
    assign bus.PCSource    = w_pcsource;
    assign bus.illegal     = w_illegal;
    assign bus.instr_count = r_count;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle successor of the single-cycle MIPS control unit: a Moore FSM that sequences each instruction over 3–5 states and emits per-state datapath strobes. It sits between the instruction register and the shared multi-cycle datapath. It stalls on a memory-ready handshake, so one unified memory with variable latency serves both fetch and data. It also keeps a retired-instruction counter and flags illegal opcodes.

## Interface
Parameters:
- OPC_W, 6, opcode width.
- CNT_W, 16, retired-instruction counter width.
- BNE_EN, 0, when 1 decode opcode 6'b001001 as bne.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- opcode  in  OPC_W  from IR, valid from DECODE onward.
- ALUZeroFlag  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegWrite, ALUSrcA  out  1 each  datapath strobes.
- RegDst  out  2  0=rt, 1=rd, 2=$31.
- DataWrite  out  2  0=ALU/mem, 1=PC+4 (jal), 2=SLT bit.
- ALUSrcB  out  2  0=reg B, 1=const 4, 2=sign-ext imm, 3=imm<<2.
- ALUOp  out  2  0=add, 1=sub, 2=slt, 3=use funct.
- PCSource  out  2  0=ALU, 1=ALUOut (branch), 2=jump target, 3=reg A (jr).
- PCWriteEn  out  1  PCWrite | (PCWriteCond & (ALUZeroFlag ^ is_bne)).
- illegal  out  1  one-cycle pulse on unknown opcode.
- instr_count  out  CNT_W  retired instructions.

## Operation
Opcode encodings: RT=0, ADDI=1, SLTI=2, LW=3, SW=4, BEQ=5, J=6, JR=7, JAL=8, BNE=9 (BNE only when BNE_EN=1).

States and transitions:
- FETCH
  - Outputs: MemRead, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0.
  - IRWrite and PCWrite assert only in the cycle mem_ready=1.
  - Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE
  - Outputs: ALUSrcA=0, ALUSrcB=3, ALUOp=0 (branch target into ALUOut).
  - Next state by opcode:
    - RT→EXEC_R
    - ADDI, SLTI→EXEC_I
    - LW, SW→MEM_ADDR
    - BEQ, BNE→BRANCH
    - J→JUMP
    - JR→JREG
    - JAL→JLINK
    - anything else→FETCH, with illegal=1 in that cycle.
- EXEC_R: ALUSrcA=1, ALUSrcB=0, ALUOp=3. Next ALU_WB.
- EXEC_I: ALUSrcA=1, ALUSrcB=2; ALUOp=0 (addi) or 2 (slti). Next ALU_WB.
- ALU_WB
  - RegWrite.
  - RegDst=1 for RT, otherwise 0.
  - DataWrite=2 for SLTI, otherwise 0.
  - Next FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Next MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: MemRead, IorD=1. Hold until mem_ready, then MEM_WB.
- MEM_WB: RegWrite, MemtoReg, RegDst=0. Next FETCH.
- MEM_WR: MemWrite, IorD=1. Hold until mem_ready, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond, PCSource=1. Next FETCH.
- JUMP: PCWrite, PCSource=2. Next FETCH.
- JREG: PCWrite, PCSource=3. Next FETCH.
- JLINK: PCWrite, PCSource=2, RegWrite, RegDst=2, DataWrite=1. Next FETCH.

Output defaults: every output not listed for a state is 0.

Counter:
- instr_count increments by 1 on each transition into FETCH from a terminal state (ALU_WB, MEM_WB, MEM_WR, BRANCH, JUMP, JREG, JLINK).
- It does not increment on an illegal-opcode return.
- It wraps modulo 2^CNT_W.

## Timing
- State register updates on the clk rising edge. Outputs are combinational from state and the latched opcode (Moore, plus the PCWriteEn term).
- Reset: asynchronous on rst=0 → state=FETCH, instr_count=0, illegal=0.
  - While in reset, MemRead still reflects FETCH, but IRWrite, PCWrite and PCWriteEn are forced to 0.
- Zero-wait memory (mem_ready tied 1), cycles per instruction:
  - R-type, addi, slti: 4.
  - lw: 5.
  - sw: 4.
  - beq, bne, j, jr, jal: 3.
- Each wait cycle adds 1. mem_ready is sampled only in FETCH, MEM_RD and MEM_WR and ignored elsewhere.
- Reset asserted mid-instruction abandons it with no counter increment. The first FETCH follows the rst rising edge.

## Structure
- Shared package mc_pkg holds:
  - opcode localparams;
  - the state enum, encoded in 4 bits;
  - ALUOp, PCSource and ALUSrcB constants.
- Single module, no sub-module. Funct decode remains in the existing ALU controller, driven by ALUOp=3.

## Test plan
- Reset, then opcode=0 (RT), mem_ready=1 → states FETCH, DECODE, EXEC_R, ALU_WB; RegWrite=1 and RegDst=1 in cycle 4; instr_count=1.
- lw with mem_ready low for 2 cycles in both FETCH and MEM_RD → 9 cycles total; MemtoReg=1 in MEM_WB; IRWrite high exactly once.
- beq, checked at PCWriteEn in BRANCH:
  - ALUZeroFlag=1 → PCWriteEn=1;
  - ALUZeroFlag=0 → PCWriteEn=0.
- BNE_EN=1 with opcode 9 → PCWriteEn follows the inverted ALUZeroFlag.
- BNE_EN=0 with opcode 9 → illegal pulse in DECODE, returns to FETCH, count unchanged.
- jal → 3 cycles; JLINK shows RegDst=2, DataWrite=1, PCSource=2.
- jr → 3 cycles; JREG shows PCSource=3.
- rst low during MEM_WR → state=FETCH and count held at its pre-instruction value.
- CNT_W=2, run 5 instructions → instr_count wraps to 1.
